// File: rtl/mod_exp_ctrl.sv
// Right-to-left square-and-multiply controller computing m^e mod n.
// Drives one external fixed-latency modular multiplier through mm_a/mm_b/mm_n,
// captures each product from mm_out, and reports via start/busy/done.
module mod_exp_ctrl #(
  parameter int WIDTH  = 32,
  parameter int MM_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] base_in,
  input  logic [WIDTH-1:0] exp_in,
  input  logic [WIDTH-1:0] mod_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  output logic [WIDTH-1:0] mm_n,
  input  logic [WIDTH-1:0] mm_out
);

  localparam int CNT_W = $clog2(MM_LAT + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MM_LAT);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RED  = 3'd2,
    MUL  = 3'd3,
    SQR  = 3'd4,
    FIN  = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] m_r;
  logic [WIDTH-1:0] n_r;
  logic [WIDTH-1:0] ex;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] base;

  // Bits of the exponent still to be processed above the current one.
  logic more_bits;
  assign more_bits = (ex[WIDTH-1:1] != '0);

  // Whole controller: sequencing, operand issue, product capture, handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      mm_a   <= '0;
      mm_b   <= '0;
      mm_n   <= '0;
      m_r    <= '0;
      n_r    <= '0;
      ex     <= '0;
      acc    <= '0;
      base   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m_r   <= base_in;
            ex    <= exp_in;
            n_r   <= mod_in;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end

        LOAD: begin
          cnt <= '0;
          if (n_r == '0) begin
            err   <= 1'b1;
            acc   <= '0;
            state <= FIN;
          end else if (ex == '0) begin
            // x^0 = 1, except that 1 mod 1 collapses to 0
            acc   <= (n_r == WIDTH'(1)) ? '0 : WIDTH'(1);
            state <= FIN;
          end else begin
            // First op is m*1 mod n, which reduces the base below n
            mm_n  <= n_r;
            mm_a  <= m_r;
            mm_b  <= WIDTH'(1);
            state <= RED;
          end
        end

        RED, MUL, SQR: begin
          if (cnt != CNT_LAST) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            cnt <= '0;
            case (state)
              RED: begin
                base <= mm_out;
                acc  <= WIDTH'(1);
                if (ex[0]) begin
                  mm_a  <= WIDTH'(1);
                  mm_b  <= mm_out;
                  state <= MUL;
                end else begin
                  // e != 0 here, so a zero LSB implies higher bits remain
                  mm_a  <= mm_out;
                  mm_b  <= mm_out;
                  state <= SQR;
                end
              end
              MUL: begin
                acc <= mm_out;
                if (more_bits) begin
                  mm_a  <= base;
                  mm_b  <= base;
                  state <= SQR;
                end else begin
                  state <= FIN;
                end
              end
              default: begin
                // SQR: new base, advance to next exponent bit
                base <= mm_out;
                ex   <= ex >> 1;
                if (ex[1]) begin
                  mm_a  <= acc;
                  mm_b  <= mm_out;
                  state <= MUL;
                end else begin
                  mm_a  <= mm_out;
                  mm_b  <= mm_out;
                  state <= SQR;
                end
              end
            endcase
          end
        end

        FIN: begin
          result <= acc;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl with a behavioural two-stage modular multiplier.
module tb_mod_exp_ctrl;

  localparam int WIDTH  = 32;
  localparam int MM_LAT = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] base_in;
  logic [WIDTH-1:0] exp_in;
  logic [WIDTH-1:0] mod_in;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] mm_a;
  logic [WIDTH-1:0] mm_b;
  logic [WIDTH-1:0] mm_n;
  logic [WIDTH-1:0] mm_out;

  int vectors = 0;
  int miscompares = 0;

  mod_exp_ctrl #(.WIDTH(WIDTH), .MM_LAT(MM_LAT)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .base_in (base_in),
    .exp_in  (exp_in),
    .mod_in  (mod_in),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .result  (result),
    .mm_a    (mm_a),
    .mm_b    (mm_b),
    .mm_n    (mm_n),
    .mm_out  (mm_out)
  );

  always #5 clk = ~clk;

  // Multiplier model: product registered, then output registered (2-cycle latency)
  logic [WIDTH-1:0] mm_p1;
  always_ff @(posedge clk) begin
    if (mm_n == '0) mm_p1 <= '0;
    else mm_p1 <= WIDTH'((64'(mm_a) * 64'(mm_b)) % 64'(mm_n));
    mm_out <= mm_p1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Start one operation and wait for done; returns result, err and latency.
  task automatic run_op(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] e,
                        input logic [WIDTH-1:0] n, output logic [WIDTH-1:0] res,
                        output logic er, output int lat);
    base_in = m; exp_in = e; mod_in = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
    lat = 0;
    res = '0;
    er  = 1'b0;
    while (lat < 3000) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    if (!done) begin
      chk("done_timeout", 0, 1);
    end else begin
      res = result;
      er  = err;
      chk("busy_low_at_done", busy, 0);
      @(posedge clk); #1;
      chk("done_one_cycle", done, 0);
    end
  endtask

  logic [WIDTH-1:0] r;
  logic             e_flag;
  int               lat;
  int               ndone;

  initial begin
    reset = 1'b0; start = 1'b0;
    base_in = '0; exp_in = '0; mod_in = '0;
    #12;
    chk("rst_busy",   busy, 0);
    chk("rst_done",   done, 0);
    chk("rst_err",    err, 0);
    chk("rst_result", result, 0);
    chk("rst_mm_a",   mm_a, 0);
    chk("rst_mm_n",   mm_n, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    run_op(4, 13, 497, r, e_flag, lat);
    chk("4^13%497", r, 445);
    chk("4^13%497_err", e_flag, 0);
    chk("4^13%497_lat", lat, 23);

    run_op(65, 17, 3233, r, e_flag, lat);
    chk("65^17%3233", r, 2790);
    chk("65^17%3233_lat", lat, 23);
    run_op(2790, 2753, 3233, r, e_flag, lat);
    chk("2790^2753%3233", r, 65);
    chk("2790^2753_lat", lat, 53);

    run_op(600, 1, 497, r, e_flag, lat);
    chk("600^1%497", r, 103);
    chk("600^1_lat", lat, 8);

    run_op(7, 0, 497, r, e_flag, lat);
    chk("7^0%497", r, 1);
    chk("7^0_lat", lat, 2);
    run_op(7, 0, 1, r, e_flag, lat);
    chk("7^0%1", r, 0);
    run_op(9, 5, 1, r, e_flag, lat);
    chk("9^5%1", r, 0);

    run_op(123, 45, 0, r, e_flag, lat);
    chk("n0_err", e_flag, 1);
    chk("n0_result", r, 0);
    chk("n0_lat", lat, 2);
    chk("n0_err_held", err, 1);
    run_op(3, 3, 10, r, e_flag, lat);
    chk("3^3%10", r, 7);
    chk("err_cleared", e_flag, 0);

    // start pulsed/held while busy must be ignored
    base_in = 4; exp_in = 13; mod_in = 497; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (i >= 3 && i <= 12) begin
        start = (i % 3 != 0);
        base_in = 9; exp_in = 3; mod_in = 11;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (i < 12) chk("result_held_busy", result, 7);
      if (done) begin
        ndone++;
        chk("ignored_start_result", result, 445);
      end
    end
    chk("ignored_start_ndone", ndone, 1);
    chk("idle_after_ignore", busy, 0);

    // asynchronous reset during a square step
    base_in = 4; exp_in = 13; mod_in = 497; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("busy_before_abort", busy, 1);
    reset = 1'b0;
    #1;
    chk("abort_busy",   busy, 0);
    chk("abort_done",   done, 0);
    chk("abort_err",    err, 0);
    chk("abort_result", result, 0);
    chk("abort_mm_a",   mm_a, 0);
    chk("abort_mm_b",   mm_b, 0);
    chk("abort_mm_n",   mm_n, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("no_done_after_abort", done, 0);
    run_op(4, 13, 497, r, e_flag, lat);
    chk("after_abort_4^13", r, 445);
    chk("after_abort_lat", lat, 23);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
